mem_stage: RTL and testbench

//  MIPS MEM stage: consumes EX/MEM pipeline-register outputs, performs loads/stores over a
//  req/ack data bus, and produces the write-back triple for the MEM/WB register.
//  Non-memory ops pass straight through. Memory ops raise stallreq until the bus access completes.

---
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: turns EX/MEM load/store requests into req/ack data-bus accesses
// and forms the write-back triple for MEM/WB, stalling the pipeline while an access is in flight.
module mem_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic        mem_wreg,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   output logic [4:0]  wb_wd,
   output logic        wb_wreg,
   output logic [31:0] wb_wdata,
   output logic        stallreq,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        bus_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [31:0]   rdata_reg, rdata_next;
   logic          abort_reg, abort_next;

   logic        is_load, is_store, is_byte, is_half, is_word, misaligned;
   logic [3:0]  sel;
   logic [31:0] store_data, load_data;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Operation decode; undefined opcodes fall out as "no memory access".
   always_comb begin
      is_load  = (mem_op >= OP_LB) && (mem_op <= OP_LW);
      is_store = (mem_op >= OP_SB) && (mem_op <= OP_SW);
      is_byte  = (mem_op == OP_LB) || (mem_op == OP_LBU) || (mem_op == OP_SB);
      is_half  = (mem_op == OP_LH) || (mem_op == OP_LHU) || (mem_op == OP_SH);
      is_word  = (mem_op == OP_LW) || (mem_op == OP_SW);
      misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));

      sel        = 4'b0000;
      store_data = mem_sdata;
      if (is_byte) begin
         sel        = 4'b0001 << mem_addr[1:0];
         store_data = {4{mem_sdata[7:0]}};
      end else if (is_half) begin
         sel        = mem_addr[1] ? 4'b1100 : 4'b0011;
         store_data = {2{mem_sdata[15:0]}};
      end else if (is_word) begin
         sel        = 4'b1111;
      end

      case (mem_addr[1:0])
         2'd0:    lane_b = dbus_rdata[7:0];
         2'd1:    lane_b = dbus_rdata[15:8];
         2'd2:    lane_b = dbus_rdata[23:16];
         default: lane_b = dbus_rdata[31:24];
      endcase
      lane_h = mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

      case (mem_op)
         OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_data = {24'd0, lane_b};
         OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_data = {16'd0, lane_h};
         default: load_data = dbus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         rdata_reg <= '0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rdata_reg <= rdata_next;
         abort_reg <= abort_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rdata_next = rdata_reg;
      abort_next = abort_reg;
      wb_wd      = 5'd0;
      wb_wreg    = 1'b0;
      wb_wdata   = 32'd0;
      stallreq   = 1'b0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = 32'd0;
      dbus_sel   = 4'd0;
      dbus_wdata = 32'd0;
      exc_adel   = 1'b0;
      exc_ades   = 1'b0;
      bus_err    = 1'b0;

      // Outputs are forced low while reset is held, including the combinational passthrough.
      if (rst) begin
         case (state_reg)
            S_IDLE: begin
               if (!(is_load || is_store)) begin
                  wb_wd    = mem_wd;
                  wb_wreg  = mem_wreg;
                  wb_wdata = mem_wdata;
               end else if (misaligned) begin
                  exc_adel = is_load;
                  exc_ades = is_store;
               end else begin
                  stallreq   = 1'b1;
                  state_next = S_BUSY;
               end
            end
            S_BUSY: begin
               stallreq   = 1'b1;
               dbus_req   = 1'b1;
               dbus_we    = is_store;
               dbus_addr  = {mem_addr[31:2], 2'b00};
               dbus_sel   = sel;
               dbus_wdata = is_store ? store_data : 32'd0;
               cnt_next   = cnt_reg + 1'b1;
               // Ack takes priority over a timeout landing in the same cycle.
               if (dbus_ack) begin
                  if (is_load) rdata_next = load_data;
                  abort_next = 1'b0;
                  state_next = S_DONE;
               end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                  bus_err    = 1'b1;
                  abort_next = 1'b1;
                  state_next = S_DONE;
               end
            end
            S_DONE: begin
               wb_wd = mem_wd;
               if (is_load && !abort_reg) begin
                  wb_wreg  = mem_wreg;
                  wb_wdata = rdata_reg;
               end
               cnt_next   = '0;
               abort_next = 1'b0;
               state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized loads/stores checked
// against a byte-lane arithmetic model of the bus and write-back behaviour.
module tb_mem_stage;

   localparam int TMO = 4;

   logic        clk, rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr, mem_sdata;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        stallreq, dbus_req, dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata, dbus_rdata;
   logic        dbus_ack, exc_adel, exc_ades, bus_err;

   int errors = 0;
   int checks = 0;

   mem_stage #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_op(mem_op),
      .mem_addr(mem_addr), .mem_sdata(mem_sdata),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
      .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int op_size(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd6: return 1;
         4'd3, 4'd4, 4'd7: return 2;
         4'd5, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic logic op_is_load(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd5);
   endfunction

   function automatic logic [3:0] exp_sel(input logic [3:0] op, input logic [31:0] addr);
      int n;
      n = op_size(op);
      return 4'(((1 << n) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] exp_store(input logic [3:0] op, input logic [31:0] s);
      int n;
      n = op_size(op);
      if (n == 1) return (s & 32'hFF) * 32'h0101_0101;
      if (n == 2) return (s & 32'hFFFF) * 32'h0001_0001;
      return s;
   endfunction

   function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                            input logic [31:0] rd);
      int n;
      logic [31:0] v, mask;
      n = op_size(op);
      if (n == 4) return rd;
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = (rd >> (8 * (addr % 4))) & mask;
      if ((op == 4'd1 || op == 4'd3) && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- one memory operation, start to finish ----------------
   // ack_at: BUSY cycle index (0-based) carrying dbus_ack; >= TMO means never ack.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                         input int ack_at, output logic [31:0] got_wdata, output int busy_cycles);
      int n, berr;
      logic ld, mis, acked;
      n  = op_size(op);
      ld = op_is_load(op);
      mis = (addr % n) != 0;
      berr = 0; acked = 1'b0; busy_cycles = 0; got_wdata = 32'hx;
      @(posedge clk); #1;
      mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wd = wd; mem_wreg = wreg;
      mem_wdata = $urandom; dbus_ack = 1'b0;
      @(negedge clk);
      checks++; if (exc_adel !== (mis && ld)) begin errors++;
         $display("FAIL exc_adel op=%0d addr=%h: got %b want %b", op, addr, exc_adel, mis && ld); end
      checks++; if (exc_ades !== (mis && !ld)) begin errors++;
         $display("FAIL exc_ades op=%0d addr=%h: got %b want %b", op, addr, exc_ades, mis && !ld); end
      checks++; if (stallreq !== !mis) begin errors++;
         $display("FAIL idle_stall op=%0d: got %b want %b", op, stallreq, !mis); end
      checks++; if (dbus_req !== 1'b0 || wb_wreg !== 1'b0 || wb_wdata !== 32'd0) begin errors++;
         $display("FAIL idle_outputs op=%0d: req=%b wreg=%b wdata=%h want 0", op, dbus_req, wb_wreg, wb_wdata); end
      if (mis) begin
         @(posedge clk); #1; mem_op = 4'd0;
         @(negedge clk);
         checks++; if (exc_adel !== 1'b0 || exc_ades !== 1'b0 || dbus_req !== 1'b0) begin errors++;
            $display("FAIL misaligned_after op=%0d: adel=%b ades=%b req=%b want 0", op, exc_adel, exc_ades, dbus_req); end
         $display("op=%0d addr=%h misaligned, exception raised", op, addr);
         return;
      end
      for (int k = 0; k < TMO && !acked; k++) begin
         @(posedge clk); #1;
         dbus_ack = (k == ack_at);
         dbus_rdata = (k == ack_at) ? rdata : $urandom;
         @(negedge clk);
         busy_cycles++;
         if (bus_err) berr++;
         checks++; if (dbus_req !== 1'b1 || stallreq !== 1'b1) begin errors++;
            $display("FAIL busy_req op=%0d cyc=%0d: req=%b stall=%b want 1", op, k, dbus_req, stallreq); end
         checks++; if (dbus_we !== !ld || dbus_addr !== (addr & ~32'h3) || dbus_sel !== exp_sel(op, addr))
         begin errors++;
            $display("FAIL busy_bus op=%0d: we=%b addr=%h sel=%b want we=%b addr=%h sel=%b", op,
                     dbus_we, dbus_addr, dbus_sel, !ld, addr & ~32'h3, exp_sel(op, addr)); end
         if (!ld) begin
            checks++; if (dbus_wdata !== exp_store(op, sdata)) begin errors++;
               $display("FAIL busy_wdata op=%0d: got %h want %h", op, dbus_wdata, exp_store(op, sdata)); end
         end
         if (k == ack_at) acked = 1'b1;
      end
      @(posedge clk); #1; dbus_ack = 1'b0;
      @(negedge clk);
      if (bus_err) berr++;
      got_wdata = wb_wdata;
      checks++; if (stallreq !== 1'b0 || dbus_req !== 1'b0) begin errors++;
         $display("FAIL done_release op=%0d: stall=%b req=%b want 0", op, stallreq, dbus_req); end
      checks++; if (wb_wd !== wd || wb_wreg !== (ld && acked && wreg)) begin errors++;
         $display("FAIL done_wb op=%0d: wd=%0d wreg=%b want wd=%0d wreg=%b", op, wb_wd, wb_wreg,
                  wd, ld && acked && wreg); end
      if (ld && acked) begin
         checks++; if (wb_wdata !== exp_load(op, addr, rdata)) begin errors++;
            $display("FAIL done_load op=%0d addr=%h: got %h want %h", op, addr, wb_wdata,
                     exp_load(op, addr, rdata)); end
      end
      checks++; if (berr !== (acked ? 0 : 1)) begin errors++;
         $display("FAIL bus_err_pulses op=%0d: got %0d want %0d", op, berr, acked ? 0 : 1); end
      $display("op=%0d addr=%h ack_at=%0d busy=%0d wb_wdata=%h", op, addr, ack_at, busy_cycles, got_wdata);
      @(posedge clk); #1; mem_op = 4'd0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      mem_op = 4'd0; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h1234; mem_addr = 32'h40;
      mem_sdata = 32'h5; dbus_ack = 1'b0; dbus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      checks++; if ({wb_wd, wb_wreg, wb_wdata, stallreq, dbus_req, dbus_we, dbus_addr, dbus_sel,
                     dbus_wdata, exc_adel, exc_ades, bus_err} !== '0) begin errors++;
         $display("FAIL reset_outputs: wb_wd=%0d wreg=%b wdata=%h stall=%b req=%b want all 0",
                  wb_wd, wb_wreg, wb_wdata, stallreq, dbus_req); end
      @(posedge clk); #1; rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_passthrough;
      logic [3:0] ops [4] = '{4'd0, 4'd9, 4'd12, 4'd15};
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         mem_op = (i == 0) ? 4'd0 : ops[i % 4];
         mem_wd = (i == 0) ? 5'd3 : 5'($urandom);
         mem_wreg = (i == 0) ? 1'b1 : 1'($urandom);
         mem_wdata = (i == 0) ? 32'h0000_1234 : $urandom;
         mem_addr = $urandom;
         @(negedge clk);
         checks++; if (wb_wd !== mem_wd || wb_wreg !== mem_wreg || wb_wdata !== mem_wdata) begin errors++;
            $display("FAIL passthrough op=%0d: wd=%0d wreg=%b wdata=%h want %0d %b %h", mem_op, wb_wd,
                     wb_wreg, wb_wdata, mem_wd, mem_wreg, mem_wdata); end
         checks++; if (stallreq !== 1'b0 || dbus_req !== 1'b0) begin errors++;
            $display("FAIL passthrough_stall op=%0d: stall=%b req=%b want 0", mem_op, stallreq, dbus_req); end
         $display("passthrough op=%0d wd=%0d wdata=%h", mem_op, mem_wd, mem_wdata);
      end
   endtask

   task automatic test_directed;
      logic [31:0] w;
      int bc;
      run_op(4'd1, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h80FF_FF7F, 1, w, bc);
      checks++; if (w !== 32'hFFFF_FF80) begin errors++;
         $display("FAIL lb_sign: got %h want ffffff80", w); end
      run_op(4'd2, 32'h1003, 32'h0, 5'd7, 1'b1, 32'h80FF_FF7F, 1, w, bc);
      checks++; if (w !== 32'h0000_0080) begin errors++;
         $display("FAIL lbu_zero: got %h want 00000080", w); end
      run_op(4'd7, 32'h2002, 32'hABCD_1234, 5'd9, 1'b1, 32'h0, 0, w, bc);
      run_op(4'd5, 32'h3001, 32'h0, 5'd4, 1'b1, 32'h0, 0, w, bc);
      run_op(4'd8, 32'h3002, 32'h0, 5'd4, 1'b1, 32'h0, 0, w, bc);
      run_op(4'd5, 32'h4000, 32'h0, 5'd6, 1'b1, 32'hDEAD_BEEF, TMO, w, bc);
      checks++; if (bc !== TMO) begin errors++;
         $display("FAIL timeout_len: got %0d busy cycles want %0d", bc, TMO); end
      run_op(4'd3, 32'h5002, 32'h0, 5'd2, 1'b1, 32'h8001_7FFF, TMO - 1, w, bc);
   endtask

   task automatic test_random;
      logic [3:0] op;
      logic [31:0] addr, w;
      int n, bc;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(1, 8));
         n = op_size(op);
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr - (addr % n);
         run_op(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(0, TMO)), w, bc);
      end
   endtask

   task automatic test_stray_ack;
      @(posedge clk); #1;
      mem_op = 4'd0; dbus_ack = 1'b1; dbus_rdata = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (stallreq !== 1'b0 || dbus_req !== 1'b0 || bus_err !== 1'b0) begin errors++;
            $display("FAIL stray_ack: stall=%b req=%b berr=%b want 0", stallreq, dbus_req, bus_err); end
      end
      @(posedge clk); #1; dbus_ack = 1'b0;
      $display("stray ack ignored in IDLE");
   endtask

   task automatic test_async_reset;
      @(posedge clk); #1;
      mem_op = 4'd5; mem_addr = 32'h6000; mem_wd = 5'd1; mem_wreg = 1'b1; dbus_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      checks++; if (dbus_req !== 1'b1) begin errors++;
         $display("FAIL async_pre: req=%b want 1", dbus_req); end
      rst = 1'b0;
      #1;
      checks++; if (dbus_req !== 1'b0 || stallreq !== 1'b0) begin errors++;
         $display("FAIL async_drop: req=%b stall=%b want 0", dbus_req, stallreq); end
      repeat (2) @(posedge clk);
      #1; mem_op = 4'd0; mem_wd = 5'd17; mem_wreg = 1'b1; mem_wdata = 32'hCAFE_0001; rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (dbus_req !== 1'b0 || stallreq !== 1'b0 || wb_wd !== 5'd17 || wb_wreg !== 1'b1 ||
                       wb_wdata !== 32'hCAFE_0001) begin errors++;
            $display("FAIL async_after: req=%b stall=%b wd=%0d wreg=%b wdata=%h", dbus_req, stallreq,
                     wb_wd, wb_wreg, wb_wdata); end
      end
      $display("async reset mid-access recovered");
   endtask

   initial begin
      test_reset;
      test_passthrough;
      test_directed;
      test_random;
      test_stray_ack;
      test_async_reset;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
